// File: rtl/inst_trace_buffer.sv
// Instruction trace buffer: captures CPU instruction words into a small FIFO and
// replays each one on a stable bus with a spaced, registered print pulse.
module inst_trace_buffer #(
    parameter int DEPTH      = 8,
    parameter int PULSE_HIGH = 2,
    parameter int GAP        = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     capture_valid,
    input  logic [31:0]              capture_inst,
    input  logic                     drain_en,
    input  logic                     clear,
    output logic [31:0]              instruction,
    output logic                     pulse,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [7:0]               dropped
);

    localparam int AW       = $clog2(DEPTH);
    localparam int CNTW     = AW + 1;
    localparam int HOLD_MAX = (PULSE_HIGH > GAP) ? PULSE_HIGH : GAP;
    localparam int CW       = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_HIGH, S_GAP} state_t;

    logic [31:0]     r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CNTW-1:0] r_count;
    logic            r_overflow;
    logic [7:0]      r_dropped;
    logic [31:0]     r_instruction;
    logic            r_pulse;
    state_t          r_state;
    logic [CW-1:0]   r_hold_cnt;

    state_t          w_next_state;
    logic [CW-1:0]   w_next_cnt;
    logic            w_pop;
    logic            w_full;
    logic            w_push;
    logic            w_drop;

    assign w_full = (r_count == CNTW'(DEPTH));
    // A full FIFO still accepts a capture when the head leaves at the same edge.
    assign w_push = capture_valid && !clear && (!w_full || w_pop);
    assign w_drop = capture_valid && !clear && w_full && !w_pop;

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_hold_cnt;
        w_pop        = 1'b0;
        if (clear) begin
            w_next_state = S_IDLE;
            w_next_cnt   = '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (drain_en && (r_count != '0)) begin
                        w_next_state = S_SETUP;
                        w_pop        = 1'b1;
                    end
                end
                S_SETUP: begin
                    w_next_state = S_HIGH;
                    w_next_cnt   = CW'(PULSE_HIGH - 1);
                end
                S_HIGH: begin
                    if (r_hold_cnt == '0) begin
                        w_next_state = S_GAP;
                        w_next_cnt   = CW'(GAP - 1);
                    end else begin
                        w_next_cnt = r_hold_cnt - 1'b1;
                    end
                end
                S_GAP: begin
                    if (r_hold_cnt == '0) begin
                        w_next_state = S_IDLE;
                    end else begin
                        w_next_cnt = r_hold_cnt - 1'b1;
                    end
                end
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    // NOTE: storage array carries no reset; entries are only read after being written.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= capture_inst;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_overflow    <= 1'b0;
            r_dropped     <= '0;
            r_instruction <= '0;
            r_pulse       <= 1'b0;
            r_state       <= S_IDLE;
            r_hold_cnt    <= '0;
        end else begin
            r_state    <= w_next_state;
            r_hold_cnt <= w_next_cnt;
            // Registered from the next state so the strobe never glitches.
            r_pulse    <= (w_next_state == S_HIGH);
            if (w_pop) r_instruction <= r_mem[r_rd_ptr];
            if (clear) begin
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_count    <= '0;
                r_overflow <= 1'b0;
                r_dropped  <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
                unique case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
                if (w_drop) begin
                    r_overflow <= 1'b1;
                    if (r_dropped != 8'hFF) r_dropped <= r_dropped + 8'd1;
                end
            end
        end
    end

    assign instruction = r_instruction;
    assign pulse       = r_pulse;
    assign count       = r_count;
    assign overflow    = r_overflow;
    assign dropped     = r_dropped;

endmodule

// File: tb/tb_inst_trace_buffer.sv
// Bench for inst_trace_buffer: queue-and-timeline reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_inst_trace_buffer;

    localparam int DEPTH  = 8;
    localparam int PH     = 2;
    localparam int GP     = 3;
    localparam int PERIOD = 2 + PH + GP;
    localparam int IDLE_T = PH + GP + 1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        capture_valid = 1'b0;
    logic [31:0] capture_inst = '0;
    logic        drain_en = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] instruction;
    logic        pulse;
    logic [3:0]  count;
    logic        overflow;
    logic [7:0]  dropped;

    int checks = 0;
    int failures = 0;

    inst_trace_buffer #(.DEPTH(DEPTH), .PULSE_HIGH(PH), .GAP(GP)) dut (
        .clk           (clk),
        .reset         (reset),
        .capture_valid (capture_valid),
        .capture_inst  (capture_inst),
        .drain_en      (drain_en),
        .clear         (clear),
        .instruction   (instruction),
        .pulse         (pulse),
        .count         (count),
        .overflow      (overflow),
        .dropped       (dropped)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of words plus cycles elapsed since the last pop.
    // t=0 setup, 1..PH pulse high, then GP low cycles, idle once t reaches IDLE_T.
    logic [31:0] m_q[$];
    logic [31:0] m_inst = '0;
    logic        m_ovf  = 1'b0;
    int          m_drop = 0;
    int          m_t    = IDLE_T;
    bit          m_full;
    bit          m_pop;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_q.delete();
            m_inst = '0;
            m_ovf  = 1'b0;
            m_drop = 0;
            m_t    = IDLE_T;
        end else if (clear) begin
            m_q.delete();
            m_ovf  = 1'b0;
            m_drop = 0;
            m_t    = IDLE_T;
        end else begin
            m_full = (m_q.size() == DEPTH);
            m_pop  = (m_t >= IDLE_T) && drain_en && (m_q.size() > 0);
            if (m_pop) begin
                m_inst = m_q.pop_front();
                m_t    = 0;
            end else if (m_t < IDLE_T) begin
                m_t++;
            end
            if (capture_valid) begin
                if (!m_full || m_pop) begin
                    m_q.push_back(capture_inst);
                end else begin
                    m_ovf = 1'b1;
                    if (m_drop < 255) m_drop++;
                end
            end
        end
    end

    // Compare process plus a log of pulse rising edges (word and cycle).
    logic [31:0] rise_word[$];
    int          rise_cyc[$];
    int          cyc = 0;
    logic        prev_pulse = 1'b0;

    always @(negedge clk) begin
        cyc++;
        check("cmp_count", count, m_q.size());
        check("cmp_overflow", overflow, m_ovf);
        check("cmp_dropped", dropped, m_drop);
        check("cmp_pulse", pulse, (m_t >= 1 && m_t <= PH) ? 1 : 0);
        check("cmp_instruction", instruction, m_inst);
        if (pulse === 1'b1 && prev_pulse === 1'b0) begin
            rise_word.push_back(instruction);
            rise_cyc.push_back(cyc);
        end
        prev_pulse = pulse;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cap(input logic [31:0] w);
        capture_valid = 1'b1;
        capture_inst  = w;
        @(negedge clk);
        capture_valid = 1'b0;
    endtask

    task automatic wait_pulse(input logic lvl, input string name);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (pulse === lvl) break;
        end
        check(name, pulse, lvl);
    endtask

    initial begin
        cycles(2);
        check("rst_pulse", pulse, 0);
        check("rst_count", count, 0);
        check("rst_instruction", instruction, 0);
        check("rst_overflow", overflow, 0);
        check("rst_dropped", dropped, 0);
        reset = 1'b1;
        cycles(2);

        // Single capture: latency and pulse shape.
        drain_en = 1'b1;
        cap(32'h8C22_0004);
        check("t1_count_after_e0", count, 1);
        cycles(1);
        check("t1_inst_after_e1", instruction, 32'h8C22_0004);
        check("t1_pulse_after_e1", pulse, 0);
        check("t1_count_after_e1", count, 0);
        cycles(1);
        check("t1_pulse_after_e2", pulse, 1);
        cycles(1);
        check("t1_pulse_after_e3", pulse, 1);
        for (int i = 0; i < 3; i++) begin
            cycles(1);
            check("t1_pulse_gap", pulse, 0);
        end
        cycles(5);

        // Burst overflow, then ordered drain with fixed spacing.
        drain_en = 1'b0;
        for (int i = 1; i <= 10; i++) cap(32'h2008_0000 + 32'(i));
        check("t2_count", count, 8);
        check("t2_overflow", overflow, 1);
        check("t2_dropped", dropped, 2);
        rise_word.delete();
        rise_cyc.delete();
        drain_en = 1'b1;
        cycles(8 * PERIOD + 5);
        check("t2_rises", rise_word.size(), 8);
        for (int i = 0; i < rise_word.size() && i < 8; i++) begin
            check("t2_word", rise_word[i], 32'h2008_0001 + 32'(i));
            if (i > 0) check("t2_spacing", rise_cyc[i] - rise_cyc[i-1], PERIOD);
        end

        // Full FIFO with simultaneous push and pop.
        clear = 1'b1;
        cycles(1);
        clear = 1'b0;
        drain_en = 1'b0;
        for (int i = 1; i <= 8; i++) cap(32'h3000_0000 + 32'(i));
        check("t3_count_full", count, 8);
        drain_en = 1'b1;
        rise_word.delete();
        rise_cyc.delete();
        cap(32'h03E0_0008);
        check("t3_count_stays", count, 8);
        check("t3_overflow", overflow, 0);
        check("t3_inst_head", instruction, 32'h3000_0001);
        cycles(9 * PERIOD + 5);
        check("t3_rises", rise_word.size(), 9);
        if (rise_word.size() == 9) check("t3_last_word", rise_word[8], 32'h03E0_0008);

        // drain_en dropped during the high phase.
        drain_en = 1'b0;
        for (int i = 1; i <= 3; i++) cap(32'h5000_0000 + 32'(i));
        rise_word.delete();
        rise_cyc.delete();
        drain_en = 1'b1;
        wait_pulse(1'b1, "t5_pulse_high");
        drain_en = 1'b0;
        cycles(15);
        check("t5_count_holds", count, 2);
        check("t5_one_rise", rise_word.size(), 1);
        check("t5_pulse_low", pulse, 0);
        drain_en = 1'b1;
        cycles(2 * PERIOD + 5);
        check("t5_resume_rises", rise_word.size(), 3);
        if (rise_word.size() >= 2) check("t5_next_word", rise_word[1], 32'h5000_0002);

        // clear during GAP together with a capture and overflow set.
        drain_en = 1'b0;
        for (int i = 1; i <= 9; i++) cap(32'h6000_0000 + 32'(i));
        check("t6_overflow_set", overflow, 1);
        drain_en = 1'b1;
        wait_pulse(1'b1, "t6_pulse_high");
        wait_pulse(1'b0, "t6_pulse_gap");
        clear = 1'b1;
        capture_valid = 1'b1;
        capture_inst = 32'hDEAD_BEEF;
        cycles(1);
        clear = 1'b0;
        capture_valid = 1'b0;
        check("t6_count", count, 0);
        check("t6_overflow", overflow, 0);
        check("t6_dropped", dropped, 0);
        rise_word.delete();
        rise_cyc.delete();
        cycles(20);
        check("t6_no_rise", rise_word.size(), 0);

        // Asynchronous reset during the high phase.
        cap(32'h4000_0001);
        cap(32'h4000_0002);
        wait_pulse(1'b1, "t4_pulse_high");
        #2;
        reset = 1'b0;
        #1;
        check("t4_async_pulse", pulse, 0);
        check("t4_async_inst", instruction, 0);
        check("t4_async_count", count, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        rise_word.delete();
        rise_cyc.delete();
        cycles(20);
        check("t4_no_rise", rise_word.size(), 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            capture_valid = ($urandom_range(0, 1) == 1);
            capture_inst  = $urandom;
            drain_en      = ($urandom_range(0, 3) != 0);
            clear         = ($urandom_range(0, 79) == 0);
            @(negedge clk);
        end
        capture_valid = 1'b0;
        clear = 1'b0;
        cycles(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_trace_buffer.md
Name: inst_trace_buffer

Overview:
- Debug-side trace stage that sits directly upstream of the instruction-print debugger.
- Captures instruction words from the CPU whenever the CPU flags a retire/fetch event and buffers them in a small FIFO.
- Replays each word on a stable `instruction` bus with a spaced `pulse`, so every entry is printed exactly once, in order, without overrunning the printer.

Parameters:
- DEPTH, 8, FIFO entries; must be a power of two and at least 2.
- PULSE_HIGH, 2, cycles `pulse` stays high per entry; at least 1.
- GAP, 3, cycles `pulse` stays low after each high phase before the next entry may start; at least 1.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- capture_valid  in  1  CPU asserts for one cycle per instruction to trace.
- capture_inst  in  32  instruction word; sampled when capture_valid=1.
- drain_en  in  1  permits replay toward the printer.
- clear  in  1  synchronous flush of FIFO, status and replay.
- instruction  out  32  word presented to the printer.
- pulse  out  1  print strobe; the printer acts on its rising edge.
- count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky flag: at least one capture was dropped.
- dropped  out  8  number of dropped captures; saturates at 255.

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO pointers, count, overflow, dropped, instruction and pulse all go to 0 immediately.
  - FSM returns to IDLE.
  - Normal operation resumes on the first clk edge after reset=1.
- Clear (clear=1 at an edge) has priority over everything except reset:
  - count, overflow and dropped go to 0; FSM goes to IDLE; pulse goes to 0.
  - instruction keeps its last value.
  - A capture in the same cycle is ignored and is not counted as dropped.
- Push: capture_valid=1 at an edge writes capture_inst at the tail when count<DEPTH, or when a pop occurs in the same edge.
  - Full with no simultaneous pop: the word is discarded, overflow is set to 1, and dropped increments (saturating at 255).
- Pop: occurs only on the IDLE->SETUP transition. The head word is loaded into the instruction register at that edge.
- count update: +1 on push only, -1 on pop only, unchanged on push+pop or on neither. count never exceeds DEPTH.
- FSM states:
  - IDLE: pulse=0. If drain_en=1 and count>0, go to SETUP and pop; otherwise stay.
  - SETUP: one cycle; instruction is stable, pulse=0. Next state is HIGH.
  - HIGH: pulse=1 for exactly PULSE_HIGH cycles, tracked by a down-counter. Then go to GAP.
  - GAP: pulse=0 for exactly GAP cycles. Then go to IDLE.
- pulse is a registered output, glitch-free.
- instruction is held constant from the SETUP cycle until the next pop, so it is stable at least one full cycle before pulse rises and throughout the high phase.
- Latency: capture at edge E0 gives instruction valid after E1 and pulse rising after E2, if the FSM was IDLE with drain_en=1.
- Replay period per entry is 2+PULSE_HIGH+GAP cycles; 7 at the defaults.
- drain_en is sampled only in IDLE. Deasserting it mid-entry lets the current entry finish; no new pop happens until drain_en=1 again.
- Ordering is strictly FIFO. Pointers wrap modulo DEPTH.

Test Plan:
1. Single capture: capture_inst=0x8C220004, drain_en=1, FSM idle, at E0 -> instruction=0x8C220004 after E1; pulse=1 after E2 and E3; pulse=0 for the next 3 cycles; count returns to 0 after E1.
2. Burst overflow: drain_en=0, 10 back-to-back captures 0x20080001..0x2008000A -> count=8, overflow=1, dropped=2. Then set drain_en=1 -> 8 rising edges of pulse, 7 cycles apart, carrying 0x20080001..0x20080008 in order.
3. Full with simultaneous push and pop: count=8, drain_en=1, FSM in IDLE, capture 0x03E00008 -> word accepted, count stays 8, overflow unchanged, and 0x03E00008 is replayed last.
4. Async reset during HIGH: drop reset without a clk edge -> pulse=0, instruction=0, count=0 immediately. After release, no pulse occurs until a new capture.
5. drain_en dropped in HIGH with 3 entries queued -> the current entry completes its full high and gap phases, no further pulse occurs, count=2 holds. Re-enabling resumes with the next word.
6. clear in the GAP cycle, together with capture_valid=1 and overflow=1 -> next cycle count=0, overflow=0, dropped=0, FSM IDLE. The captured word is absent and no pulse follows.
